mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Responder end of the datapath memory-request protocol. Accepts instruction fetches (iREN) and data load/store requests (dREN/dWEN) held level-high by the datapath until a hit.
- Serializes them onto the single-port RAM, returns registered one-cycle ihit/dhit pulses with load data, and recovers from RAM error and timeout conditions.
- Sits between the datapath and RAM.

Parameters:
- TIMEOUT, 64: max consecutive non-ACCESS cycles per RAM attempt before that attempt counts as failed.
- MAX_RETRY, 3: failed attempts allowed before the request is force-completed.
- ERR_WORD, 32'hBAD1BAD1: load data returned on a force-completed read.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- iREN  in  1  instruction read request, held until ihit.
- iaddr  in  32  instruction word address.
- ihit  out  1  one-cycle pulse, iload valid.
- iload  out  32  fetched instruction, held until the next ihit.
- dREN  in  1  data read request, held until dhit.
- dWEN  in  1  data write request, held until dhit.
- daddr  in  32  data address.
- dstore  in  32  store data.
- dhit  out  1  one-cycle pulse, data op complete.
- dload  out  32  load data, held until the next dhit.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data, valid when ramstate==ACCESS.
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- memerr  out  1  sticky: some request was force-completed.

Behaviour:
- Reset (async, any state): state IDLE. Outputs ihit, dhit, ramREN, ramWEN, memerr = 0. iload, dload, ramaddr, ramstore = 0. Wait and retry counters = 0.
- States: IDLE, DACC, IACC, HIT, COOL.
- IDLE:
  - dREN|dWEN has priority over iREN.
  - On a data request: latch daddr, dstore, and op (dWEN wins if both dREN and dWEN are high) -> DACC.
  - Else on iREN: latch iaddr -> IACC.
  - Otherwise stay in IDLE.
- DACC/IACC:
  - Registered RAM outputs are driven from the latched op/address/data. ramREN/ramWEN are asserted only in these states; ramREN and ramWEN are never both high.
  - ramstate==ACCESS: capture ramload into dload (read) or iload (fetch). Store leaves dload unchanged. -> HIT.
  - ramstate==ERROR, or wait counter reaches TIMEOUT-1: attempt failed. Increment retry, clear wait, deassert RAM enables for one cycle, then re-drive.
  - Retry reaching MAX_RETRY: force-complete. Reads return ERR_WORD; stores are dropped. memerr <= 1. -> HIT.
  - FREE/BUSY otherwise: increment wait.
- HIT: pulse exactly one of dhit/ihit for one cycle; clear counters; -> COOL.
- COOL: one cycle, requests ignored. This covers the requester dropping its registered enable one cycle after the hit. -> IDLE.
- Latency:
  - Request high in cycle 0 -> RAM enable in cycle 1.
  - ACCESS in cycle N -> hit in cycle N+1.
  - Earliest next acceptance is cycle N+3.
- Requests are never preempted mid-access. An iREN arriving during a data op waits, and vice versa.
- Input changes after acceptance are ignored until the next IDLE.
- memerr clears only on reset.
- Wait counter saturates internally. Counter widths are $clog2(TIMEOUT+1) and $clog2(MAX_RETRY+1).

Test Plan:
- Fetch: iREN=1, iaddr=0x40; RAM BUSY 2 cycles, then ACCESS with ramload=0x8C220004 -> ramREN=1 with ramaddr=0x40 one cycle after the request; ihit pulses 1 cycle later; iload=0x8C220004; ramREN drops.
- Priority: iREN and dREN asserted in the same cycle, daddr=0x100, ramload=0xDEADBEEF -> data served first (dhit, dload=0xDEADBEEF); the fetch is then accepted after COOL; no overlap of ramREN between the two requests.
- Store: dWEN=1, daddr=0x200, dstore=0x12345678; ACCESS after 1 cycle -> ramWEN=1, ramstore=0x12345678, ramREN=0; dhit pulses once; dload unchanged.
- Error retry: read with ramstate=ERROR twice, then ACCESS with ramload=0x00000007 -> two one-cycle enable drops; dhit; dload=7; memerr=0.
- Timeout force-complete: TIMEOUT=4, ramstate stuck at BUSY -> 3 failed attempts; dhit; dload=0xBAD1BAD1; memerr=1 and stays 1.
- Reset mid-op: nRST low while in DACC -> all outputs immediately 0; after release, a held dREN is re-accepted from IDLE and completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Serializes datapath instruction fetches and data loads/stores onto one
// single-port RAM, with retry on RAM error/timeout and forced completion.
module mem_arbiter #(
  parameter int          TIMEOUT   = 64,
  parameter int          MAX_RETRY = 3,
  parameter logic [31:0] ERR_WORD  = 32'hBAD1BAD1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        ihit,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dhit,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        memerr,
  output logic [2:0]  o_dbg_state
);

  // Handshake: a requester holds iREN or dREN/dWEN high until it sees a
  // one-cycle ihit/dhit; the hit is the only acknowledge, there is no ready.
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DACC = 3'd1,
    S_IACC = 3'd2,
    S_HIT  = 3'd3,
    S_COOL = 3'd4
  } state_t;

  state_t          r_state, w_state_nx;
  logic            r_op_wr, w_op_wr_nx;
  logic            r_drop, w_drop_nx;
  logic [WW-1:0]   r_wait, w_wait_nx, w_wait_inc;
  logic [RW-1:0]   r_retry, w_retry_nx, w_retry_inc;
  logic            r_ihit, w_ihit_nx;
  logic            r_dhit, w_dhit_nx;
  logic            r_ramren, w_ramren_nx;
  logic            r_ramwen, w_ramwen_nx;
  logic [31:0]     r_ramaddr, w_ramaddr_nx;
  logic [31:0]     r_ramstore, w_ramstore_nx;
  logic [31:0]     r_iload, w_iload_nx;
  logic [31:0]     r_dload, w_dload_nx;
  logic            r_memerr, w_memerr_nx;

  logic w_data_req, w_in_acc, w_live, w_access, w_fail, w_give_up;

  assign w_data_req  = dREN | dWEN;
  assign w_in_acc    = (r_state == S_DACC) || (r_state == S_IACC);
  // r_drop marks the single enable-low cycle between failed and next attempt.
  assign w_live      = w_in_acc && !r_drop;
  assign w_access    = w_live && (ramstate == RAM_ACCESS);
  assign w_fail      = w_live && !w_access &&
                       ((ramstate == RAM_ERROR) || (r_wait == WW'(TIMEOUT - 1)));
  assign w_retry_inc = r_retry + 1'b1;
  assign w_give_up   = w_fail && (w_retry_inc == RW'(MAX_RETRY));
  assign w_wait_inc  = (r_wait == {WW{1'b1}}) ? r_wait : r_wait + 1'b1;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_data_req)  w_state_nx = S_DACC;
        else if (iREN)   w_state_nx = S_IACC;
      end
      S_DACC, S_IACC: begin
        if (w_access || w_give_up) w_state_nx = S_HIT;
      end
      S_HIT:   w_state_nx = S_COOL;
      S_COOL:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    w_ihit_nx     = 1'b0;
    w_dhit_nx     = 1'b0;
    w_ramren_nx   = r_ramren;
    w_ramwen_nx   = r_ramwen;
    w_ramaddr_nx  = r_ramaddr;
    w_ramstore_nx = r_ramstore;
    w_iload_nx    = r_iload;
    w_dload_nx    = r_dload;
    w_memerr_nx   = r_memerr;
    w_op_wr_nx    = r_op_wr;
    w_drop_nx     = r_drop;
    w_wait_nx     = r_wait;
    w_retry_nx    = r_retry;
    case (r_state)
      S_IDLE: begin
        if (w_data_req) begin
          // A simultaneous dREN and dWEN is treated as a store.
          w_op_wr_nx    = dWEN;
          w_ramaddr_nx  = daddr;
          w_ramstore_nx = dstore;
          w_ramwen_nx   = dWEN;
          w_ramren_nx   = ~dWEN;
        end else if (iREN) begin
          w_op_wr_nx   = 1'b0;
          w_ramaddr_nx = iaddr;
          w_ramren_nx  = 1'b1;
          w_ramwen_nx  = 1'b0;
        end
      end
      S_DACC, S_IACC: begin
        if (r_drop) begin
          w_drop_nx   = 1'b0;
          w_ramren_nx = ~r_op_wr;
          w_ramwen_nx = r_op_wr;
        end else if (w_access || w_give_up) begin
          w_ramren_nx = 1'b0;
          w_ramwen_nx = 1'b0;
          if (r_state == S_IACC) begin
            w_ihit_nx  = 1'b1;
            w_iload_nx = w_access ? ramload : ERR_WORD;
          end else begin
            w_dhit_nx = 1'b1;
            if (!r_op_wr) w_dload_nx = w_access ? ramload : ERR_WORD;
          end
          if (w_give_up) w_memerr_nx = 1'b1;
        end else if (w_fail) begin
          w_retry_nx  = w_retry_inc;
          w_wait_nx   = '0;
          w_drop_nx   = 1'b1;
          w_ramren_nx = 1'b0;
          w_ramwen_nx = 1'b0;
        end else begin
          w_wait_nx = w_wait_inc;
        end
      end
      S_HIT: begin
        w_wait_nx  = '0;
        w_retry_nx = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_ihit     <= 1'b0;
      r_dhit     <= 1'b0;
      r_ramren   <= 1'b0;
      r_ramwen   <= 1'b0;
      r_ramaddr  <= '0;
      r_ramstore <= '0;
      r_iload    <= '0;
      r_dload    <= '0;
      r_memerr   <= 1'b0;
      r_op_wr    <= 1'b0;
      r_drop     <= 1'b0;
      r_wait     <= '0;
      r_retry    <= '0;
    end else begin
      r_ihit     <= w_ihit_nx;
      r_dhit     <= w_dhit_nx;
      r_ramren   <= w_ramren_nx;
      r_ramwen   <= w_ramwen_nx;
      r_ramaddr  <= w_ramaddr_nx;
      r_ramstore <= w_ramstore_nx;
      r_iload    <= w_iload_nx;
      r_dload    <= w_dload_nx;
      r_memerr   <= w_memerr_nx;
      r_op_wr    <= w_op_wr_nx;
      r_drop     <= w_drop_nx;
      r_wait     <= w_wait_nx;
      r_retry    <= w_retry_nx;
    end
  end

  assign ihit        = r_ihit;
  assign dhit        = r_dhit;
  assign iload       = r_iload;
  assign dload       = r_dload;
  assign ramREN      = r_ramren;
  assign ramWEN      = r_ramwen;
  assign ramaddr     = r_ramaddr;
  assign ramstore    = r_ramstore;
  assign memerr      = r_memerr;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: behavioural RAM responder, hit scoreboard
// fed by the stimulus, and a negedge monitor that pops and compares.
module tb_mem_arbiter;

  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore;
  logic        ihit, dhit, ramREN, ramWEN, memerr;
  logic [31:0] iload, dload, ramaddr, ramstore, ramload;
  logic [1:0]  ramstate;
  logic [2:0]  o_dbg_state;

  mem_arbiter #(.TIMEOUT(4), .MAX_RETRY(3), .ERR_WORD(32'hBAD1BAD1)) u_dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dhit(dhit), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .memerr(memerr),
    .o_dbg_state(o_dbg_state)
  );

  // clock / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected summary first");
    $fatal(1, "watchdog expired");
  end

  // behavioural RAM: optional ERROR responses, then BUSY for cfg_lat cycles
  int          en_cnt, err_seen;
  int          cfg_lat, cfg_err_until;
  logic        cfg_stuck;
  logic [31:0] cfg_rdata;
  logic        ram_en;

  assign ram_en  = ramREN | ramWEN;
  assign ramload = cfg_rdata;

  always_comb begin
    ramstate = FREE;
    if (ram_en) begin
      if (err_seen < cfg_err_until) ramstate = ERROR;
      else if (cfg_stuck)           ramstate = BUSY;
      else if (en_cnt >= cfg_lat)   ramstate = ACCESS;
      else                          ramstate = BUSY;
    end
  end

  always_ff @(posedge CLK) begin
    en_cnt <= ram_en ? en_cnt + 1 : 0;
    if (ramstate == ERROR) err_seen <= err_seen + 1;
  end

  // scoreboard: bit 32 = data-side hit, bits 31:0 = expected load value
  logic [32:0] exp_q[$];
  logic [32:0] mon_e;
  int          checks, errors, rises;
  bit          prev_en;
  logic [31:0] last_rise_addr;

  initial begin
    forever begin
      @(negedge CLK);
      if (ram_en && !prev_en) begin
        rises++;
        last_rise_addr = ramaddr;
      end
      prev_en = ram_en;
      if (ram_en) begin
        checks++;
        if (ramREN && ramWEN) begin
          errors++;
          $display("FAIL ram_en_excl: ramREN=%b ramWEN=%b, expected not both", ramREN, ramWEN);
        end
      end
      if (ihit || dhit) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_hit: ihit=%b dhit=%b with empty queue", ihit, dhit);
        end else begin
          mon_e = exp_q.pop_front();
          if ({dhit, ihit} !== {mon_e[32], ~mon_e[32]} ||
              (mon_e[32] ? dload : iload) !== mon_e[31:0]) begin
            errors++;
            $display("FAIL hit_data: got dhit=%b ihit=%b load=%h, expected dside=%b load=%h",
                     dhit, ihit, mon_e[32] ? dload : iload, mon_e[32], mon_e[31:0]);
          end
        end
      end
    end
  end

  // driver / check tasks
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic wait_hit(output int n);
    n = 0;
    @(negedge CLK);
    while (!(ihit || dhit) && n < 300) begin
      n++;
      @(negedge CLK);
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL hit_timeout: no hit after %0d cycles, expected one", n);
    end
  endtask

  task automatic drop_reqs();
    @(posedge CLK); #1;
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
  endtask

  task automatic next_idle();
    @(posedge CLK); #1;
  endtask

  int n, r0;

  initial begin
    iREN = 0; dREN = 0; dWEN = 0; iaddr = 0; daddr = 0; dstore = 0;
    cfg_lat = 0; cfg_err_until = 0; cfg_stuck = 0; cfg_rdata = 0;
    nRST = 0;
    repeat (2) @(negedge CLK);
    chk1("rst_ihit", ihit, 1'b0);      chk1("rst_dhit", dhit, 1'b0);
    chk1("rst_ramREN", ramREN, 1'b0);  chk1("rst_ramWEN", ramWEN, 1'b0);
    chk1("rst_memerr", memerr, 1'b0);  chk("rst_iload", iload, 32'h0);
    chk("rst_dload", dload, 32'h0);    chk("rst_ramaddr", ramaddr, 32'h0);
    chk("rst_ramstore", ramstore, 32'h0);
    chk("rst_state", 32'(o_dbg_state), 32'd0);
    @(posedge CLK); #1 nRST = 1;
    repeat (2) @(posedge CLK);
    #1;

    // fetch: BUSY 2 cycles, then ACCESS
    cfg_lat = 2; cfg_rdata = 32'h8C220004; iREN = 1; iaddr = 32'h40;
    exp_q.push_back({1'b0, 32'h8C220004});
    @(negedge CLK); chk1("fetch_no_early_en", ramREN, 1'b0);
    @(negedge CLK); chk1("fetch_ramREN", ramREN, 1'b1);
    chk("fetch_ramaddr", ramaddr, 32'h40); chk1("fetch_ramWEN", ramWEN, 1'b0);
    wait_hit(n); chk("fetch_latency", 32'(n), 32'd2);
    chk1("fetch_en_dropped", ramREN, 1'b0);
    drop_reqs();
    @(negedge CLK); chk1("fetch_hit_width", ihit, 1'b0);

    // priority: data and fetch together
    next_idle();
    r0 = rises; cfg_lat = 1; cfg_rdata = 32'hDEADBEEF;
    iREN = 1; iaddr = 32'h80; dREN = 1; daddr = 32'h100;
    exp_q.push_back({1'b1, 32'hDEADBEEF});
    exp_q.push_back({1'b0, 32'h11112222});
    wait_hit(n); #1;
    chk1("prio_data_first", dhit, 1'b1); chk("prio_data_lat", 32'(n), 32'd3);
    chk("prio_rises1", 32'(rises - r0), 32'd1); chk("prio_addr1", last_rise_addr, 32'h100);
    @(posedge CLK); #1 dREN = 0; cfg_rdata = 32'h11112222;
    wait_hit(n); #1;
    chk("prio_fetch_lat", 32'(n), 32'd4);
    chk("prio_rises2", 32'(rises - r0), 32'd2); chk("prio_addr2", last_rise_addr, 32'h80);
    drop_reqs();
    @(negedge CLK);

    // store: dload must keep the previous load value
    next_idle();
    cfg_lat = 1; dWEN = 1; daddr = 32'h200; dstore = 32'h12345678;
    exp_q.push_back({1'b1, 32'hDEADBEEF});
    @(negedge CLK);
    @(negedge CLK);
    chk1("store_ramWEN", ramWEN, 1'b1); chk1("store_ramREN", ramREN, 1'b0);
    chk("store_ramstore", ramstore, 32'h12345678); chk("store_ramaddr", ramaddr, 32'h200);
    wait_hit(n); chk("store_latency", 32'(n), 32'd1);
    drop_reqs();
    @(negedge CLK); chk1("store_hit_width", dhit, 1'b0);

    // two RAM errors, then success
    next_idle();
    r0 = rises; cfg_lat = 0; cfg_rdata = 32'h7; cfg_err_until = err_seen + 2;
    dREN = 1; daddr = 32'h300;
    exp_q.push_back({1'b1, 32'h7});
    wait_hit(n); #1;
    chk("err_latency", 32'(n), 32'd6);
    chk("err_attempts", 32'(rises - r0), 32'd3);
    chk1("err_memerr", memerr, 1'b0);
    drop_reqs();
    @(negedge CLK);

    // stuck BUSY: three timed-out attempts, forced completion
    next_idle();
    r0 = rises; cfg_stuck = 1; dREN = 1; daddr = 32'h400;
    exp_q.push_back({1'b1, 32'hBAD1BAD1});
    wait_hit(n); #1;
    chk("tmo_latency", 32'(n), 32'd15);
    chk("tmo_attempts", 32'(rises - r0), 32'd3);
    chk1("tmo_memerr", memerr, 1'b1);
    drop_reqs();
    cfg_stuck = 0;
    @(negedge CLK);
    next_idle();
    cfg_lat = 0; cfg_rdata = 32'h55; dREN = 1; daddr = 32'h404;
    exp_q.push_back({1'b1, 32'h55});
    wait_hit(n); #1;
    chk("after_tmo_latency", 32'(n), 32'd2);
    chk1("memerr_sticky", memerr, 1'b1);
    drop_reqs();
    @(negedge CLK);

    // asynchronous reset while in DACC
    next_idle();
    cfg_stuck = 1; dREN = 1; daddr = 32'h500;
    repeat (3) @(negedge CLK);
    chk("mid_state", 32'(o_dbg_state), 32'd1); chk1("mid_ramREN", ramREN, 1'b1);
    #2 nRST = 0;
    #1;
    chk1("arst_ramREN", ramREN, 1'b0); chk1("arst_ramWEN", ramWEN, 1'b0);
    chk1("arst_memerr", memerr, 1'b0); chk1("arst_dhit", dhit, 1'b0);
    chk("arst_dload", dload, 32'h0);   chk("arst_iload", iload, 32'h0);
    chk("arst_ramaddr", ramaddr, 32'h0);
    chk("arst_state", 32'(o_dbg_state), 32'd0);
    cfg_stuck = 0; cfg_lat = 1; cfg_rdata = 32'h66;
    exp_q.push_back({1'b1, 32'h66});
    @(posedge CLK); #1 nRST = 1;
    wait_hit(n); #1;
    chk("rearm_latency", 32'(n), 32'd3);
    chk1("rearm_memerr", memerr, 1'b0);
    drop_reqs();
    repeat (3) @(negedge CLK);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
